tb_clk_gen_mc: RTL and testbench
================================

TB_CLK_GEN_MC -- requirements
Module: tb_clk_gen_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent generated clock channels.
REQ-002 SHALL have parameter DIV_W, default 8: width of the per-channel divide ratio.
REQ-003 SHALL have parameter DLY_W, default 16: width of the per-channel start-delay count.
REQ-004 SHALL have parameter RST_DIV, default 2: reset value of every channel's divide ratio.
REQ-005 SHALL have parameter LOCK_CYCLES, default 4: number of full output periods before lock is asserted.
REQ-006 SHALL have port clk_i, input, 1 bit: reference clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port en_i, input, N_CH bits: per-channel run request, level-sensitive.
REQ-009 SHALL have port cfg_valid_i, input, 1 bit: configuration write request.
REQ-010 SHALL have port cfg_ready_o, output, 1 bit: configuration write accepted this cycle.
REQ-011 SHALL have port cfg_ch_i, input, $clog2(N_CH) bits (minimum 1): target channel of the write.
REQ-012 SHALL have port cfg_div_i, input, DIV_W bits: divide ratio, in reference cycles per output period.
REQ-013 SHALL have port cfg_dly_i, input, DLY_W bits: start delay, in reference cycles.
REQ-014 SHALL have port clk_o, output, N_CH bits: generated clocks, driven directly from flops.
REQ-015 SHALL have port busy_o, output, N_CH bits: channel is in any state other than IDLE.
REQ-016 SHALL have port lock_o, output, N_CH bits: channel is stable (present only when the lock feature is compiled in).

Function
REQ-017 Each channel SHALL run its own FSM with states IDLE, DELAY, RUN and STOP.
REQ-018 IDLE SHALL go to DELAY when en_i[ch]=1; if dly=0, IDLE SHALL instead go directly to RUN on the same edge.
REQ-019 DELAY SHALL count dly reference cycles and then go to RUN; clk_o[ch]=0 throughout DELAY.
REQ-020 In RUN, the output period SHALL be div cycles: high for div/2 cycles (rounded down), then low for div-div/2 cycles.
REQ-021 The first RUN cycle SHALL drive clk_o[ch]=1.
REQ-022 An effective div value below 2 SHALL be clamped to 2.
REQ-023 Dropping en_i in RUN SHALL go to STOP; STOP SHALL finish the current period, then go to IDLE with clk_o low, so no runt pulse is produced.
REQ-024 Dropping en_i in DELAY SHALL return the channel to IDLE immediately.
REQ-025 Re-asserting en_i in STOP SHALL return the channel to RUN without breaking the current period.
REQ-026 cfg_ready_o SHALL equal cfg_valid_i AND (target channel in IDLE) AND (cfg_ch_i < N_CH).
REQ-027 A write SHALL be accepted when cfg_valid_i and cfg_ready_o are both 1, and the new values SHALL take effect on the next IDLE exit.
REQ-028 An accepted write and a rising en_i on the same channel in the same cycle SHALL use the newly written values.
REQ-029 An out-of-range cfg_ch_i SHALL never be accepted, leaving cfg_ready_o=0 indefinitely.
REQ-030 The period and delay counters SHALL use DIV_W and DLY_W bits, with no wrap-around inside a period.

Reset
REQ-031 On rst_ni=0, asynchronously: all channels go to IDLE; clk_o=0, busy_o=0, lock_o=0, cfg_ready_o=0; div=RST_DIV and dly=0 for every channel.
REQ-032 Reset asserted mid-period SHALL force clk_o low immediately.
REQ-033 After reset release, the first possible clk_o rise SHALL be on the first clk_i edge at which en_i=1.

Configuration
REQ-034 The lock feature SHALL be controlled by macro TB_CLK_GEN_MC_LOCK_EN.
REQ-035 With TB_CLK_GEN_MC_LOCK_EN defined, lock_o[ch] SHALL rise at the start of the period that follows LOCK_CYCLES complete RUN periods, and SHALL clear on leaving RUN or STOP.
REQ-036 Without TB_CLK_GEN_MC_LOCK_EN, port lock_o and its counters SHALL be absent.

Structure
REQ-037 Package tb_clk_gen_pkg SHALL hold the FSM state enum (clk_gen_state_e) and the minimum divide constant (MIN_DIV=2).
REQ-038 One sub-module, tb_clk_gen_ch, SHALL implement a single channel (FSM, counters, lock logic); the top SHALL instantiate N_CH of them and hold the config decode.

Verification
REQ-039 Reset release, write ch0 div=4 dly=3, en_i[0]=1 -> clk_o[0] low for 3 cycles, then the pattern 1,1,0,0 repeating.
REQ-040 Write ch1 div=5 dly=0, en_i[1]=1 -> clk_o[1] rises on the same edge, high 2 cycles and low 3, with ch0 unaffected.
REQ-041 Drop en_i[0] in the first high cycle of a div=4 period -> 1 more high cycle and 2 low cycles, then IDLE, busy_o[0]=0, and no short pulse.
REQ-042 cfg write to a RUN channel -> cfg_ready_o=0 and running period unchanged; write div=1 -> output behaves as div=2 (toggles every cycle).
REQ-043 With LOCK_EN, div=4 -> lock_o rises 16 cycles after the first rise; without LOCK_EN, elaboration succeeds with no lock_o port.
REQ-044 rst_ni pulsed low while clk_o=1 -> clk_o=0 asynchronously and all state IDLE.

Source files
------------

// File: rtl/tb_clk_gen_pkg.sv
// Shared types and constants for the multi-channel reference-clock divider.
package tb_clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } clk_gen_state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/tb_clk_gen_ch.sv
// One generated-clock channel: start delay, glitch-free divided output, optional lock.
// Lock logic is built only when TB_CLK_GEN_MC_LOCK_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | output low, waiting for en_i
// ST_DELAY | output low, counting down the start delay
// ST_RUN   | producing periods of div reference cycles
// ST_STOP  | en_i dropped; finishing the current period before idling
module tb_clk_gen_ch
  import tb_clk_gen_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DLY_W       = 16,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DLY_W-1:0] dly_i,
`ifdef TB_CLK_GEN_MC_LOCK_EN
  output logic             lock_o,
`endif
  output logic             clk_o,
  output logic             busy_o
);

  clk_gen_state_e   state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DIV_W-1:0] div_c, lo_c;
  logic             clk_d;

  assign div_c = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
  // Period counter counts down from div-1; output is high while count >= low-phase length.
  assign lo_c  = div_c - (div_c >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    clk_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          if (dly_i == '0) begin
            state_d = ST_RUN;
            cnt_d   = div_c - DIV_W'(1);
            clk_d   = 1'b1;
          end else begin
            state_d = ST_DELAY;
            dly_d   = dly_i - DLY_W'(1);
          end
        end
      end
      ST_DELAY: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (dly_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = div_c - DIV_W'(1);
          clk_d   = 1'b1;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ST_RUN, ST_STOP: begin
        state_d = en_i ? ST_RUN : ST_STOP;
        if (cnt_q == '0) begin
          if (en_i) begin
            cnt_d = div_c - DIV_W'(1);
            clk_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
          clk_d = (cnt_d >= lo_c);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      clk_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      clk_o   <= clk_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

`ifdef TB_CLK_GEN_MC_LOCK_EN
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  logic [LC_W-1:0] lock_cnt_q;
  logic            restart;

  // A restart marks the completion of one full period that continues into the next.
  assign restart = ((state_q == ST_RUN) || (state_q == ST_STOP)) && (cnt_q == '0) && en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_cnt_q <= '0;
      lock_o     <= 1'b0;
    end else if (state_d == ST_IDLE) begin
      lock_cnt_q <= '0;
      lock_o     <= 1'b0;
    end else if (restart) begin
      if (lock_cnt_q != LC_W'(LOCK_CYCLES)) lock_cnt_q <= lock_cnt_q + LC_W'(1);
      if (lock_cnt_q >= LC_W'(LOCK_CYCLES - 1)) lock_o <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/tb_clk_gen_mc.sv
// Multi-channel clock generator: per-channel config registers with write decode.
// Optional lock outputs are enabled with macro TB_CLK_GEN_MC_LOCK_EN.
module tb_clk_gen_mc
  import tb_clk_gen_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = 8,
  parameter int DLY_W       = 16,
  parameter int RST_DIV     = 2,
  parameter int LOCK_CYCLES = 4,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_CH-1:0]  en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [DLY_W-1:0] cfg_dly_i,
  output logic [N_CH-1:0]  clk_o,
`ifdef TB_CLK_GEN_MC_LOCK_EN
  output logic [N_CH-1:0]  lock_o,
`endif
  output logic [N_CH-1:0]  busy_o
);

  logic tgt_idle;

  // Out-of-range channel numbers match no channel and so are never ready.
  always_comb begin
    tgt_idle = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (int'(cfg_ch_i) == ch) tgt_idle = !busy_o[ch];
    end
  end

  assign cfg_ready_o = rst_ni & cfg_valid_i & tgt_idle;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             wr;
    logic [DIV_W-1:0] div_q, div_eff;
    logic [DLY_W-1:0] dly_q, dly_eff;

    assign wr = cfg_ready_o && (int'(cfg_ch_i) == g);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        div_q <= DIV_W'(RST_DIV);
        dly_q <= '0;
      end else if (wr) begin
        div_q <= cfg_div_i;
        dly_q <= cfg_dly_i;
      end
    end

    // Bypass lets a write and an IDLE exit in the same cycle use the new values.
    assign div_eff = wr ? cfg_div_i : div_q;
    assign dly_eff = wr ? cfg_dly_i : dly_q;

    tb_clk_gen_ch #(
      .DIV_W       (DIV_W),
      .DLY_W       (DLY_W),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en_i[g]),
      .div_i  (div_eff),
      .dly_i  (dly_eff),
`ifdef TB_CLK_GEN_MC_LOCK_EN
      .lock_o (lock_o[g]),
`endif
      .clk_o  (clk_o[g]),
      .busy_o (busy_o[g])
    );
  end

endmodule

// File: tb/tb_tb_clk_gen_mc.sv
// Self-checking bench for tb_clk_gen_mc: directed scenarios plus randomized traffic
// against a period/phase reference model.
module tb_tb_clk_gen_mc;

  localparam int N_CH        = 3;
  localparam int DIV_W       = 8;
  localparam int DLY_W       = 16;
  localparam int LOCK_CYCLES = 4;

  logic             clk_i;
  logic             rst_ni;
  logic [N_CH-1:0]  en_i;
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [1:0]       cfg_ch_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic [DLY_W-1:0] cfg_dly_i;
  logic [N_CH-1:0]  clk_o;
  logic [N_CH-1:0]  busy_o;
`ifdef TB_CLK_GEN_MC_LOCK_EN
  logic [N_CH-1:0]  lock_o;
`endif

  int checks;
  int failures;

  tb_clk_gen_mc #(
    .N_CH        (N_CH),
    .DIV_W       (DIV_W),
    .DLY_W       (DLY_W),
    .RST_DIV     (2),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_dly_i   (cfg_dly_i),
    .clk_o       (clk_o),
`ifdef TB_CLK_GEN_MC_LOCK_EN
    .lock_o      (lock_o),
`endif
    .busy_o      (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference model: a channel is idle, waiting out a delay, or running at some
  // phase within its period; the output is high during the first div/2 phases.
  int m_div_cfg [N_CH];
  int m_dly_cfg [N_CH];
  int m_div     [N_CH];
  int m_phase   [N_CH];
  int m_left    [N_CH];
  int m_periods [N_CH];
  bit m_run     [N_CH];
  bit m_wait    [N_CH];

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_div_cfg[ch] = 2; m_dly_cfg[ch] = 0; m_div[ch] = 2;
      m_phase[ch] = 0; m_left[ch] = 0; m_periods[ch] = 0;
      m_run[ch] = 0; m_wait[ch] = 0;
    end
  endtask

  function automatic bit model_ready();
    if (!cfg_valid_i) return 1'b0;
    if (int'(cfg_ch_i) >= N_CH) return 1'b0;
    return !m_run[cfg_ch_i] && !m_wait[cfg_ch_i];
  endfunction

  task automatic model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      if (cfg_valid_i && int'(cfg_ch_i) == ch && !m_run[ch] && !m_wait[ch]) begin
        m_div_cfg[ch] = int'(cfg_div_i);
        m_dly_cfg[ch] = int'(cfg_dly_i);
      end
      if (m_run[ch]) begin
        m_phase[ch]++;
        if (m_phase[ch] == m_div[ch]) begin
          if (en_i[ch]) begin m_phase[ch] = 0; m_periods[ch]++; end
          else m_run[ch] = 0;
        end
      end else if (m_wait[ch]) begin
        if (!en_i[ch]) m_wait[ch] = 0;
        else begin
          m_left[ch]--;
          if (m_left[ch] == 0) begin
            m_wait[ch] = 0; m_run[ch] = 1; m_phase[ch] = 0; m_periods[ch] = 0;
          end
        end
      end else if (en_i[ch]) begin
        m_div[ch] = (m_div_cfg[ch] < 2) ? 2 : m_div_cfg[ch];
        if (m_dly_cfg[ch] == 0) begin
          m_run[ch] = 1; m_phase[ch] = 0; m_periods[ch] = 0;
        end else begin
          m_wait[ch] = 1; m_left[ch] = m_dly_cfg[ch];
        end
      end
    end
  endtask

  function automatic logic [N_CH-1:0] exp_clk();
    logic [N_CH-1:0] v;
    v = '0;
    for (int ch = 0; ch < N_CH; ch++) v[ch] = m_run[ch] && (m_phase[ch] < m_div[ch] / 2);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_busy();
    logic [N_CH-1:0] v;
    v = '0;
    for (int ch = 0; ch < N_CH; ch++) v[ch] = m_run[ch] || m_wait[ch];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_lock();
    logic [N_CH-1:0] v;
    v = '0;
    for (int ch = 0; ch < N_CH; ch++) v[ch] = m_run[ch] && (m_periods[ch] >= LOCK_CYCLES);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; en_i = '0; cfg_valid_i = 1'b0;
    cfg_ch_i = '0; cfg_div_i = '0; cfg_dly_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = '1; cfg_valid_i = 1'b1; cfg_ch_i = '0;
    cfg_div_i = '0; cfg_dly_i = '0;
    #2;
    checks++;
    if (clk_o !== '0 || busy_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs clk_o=%b busy_o=%b required 000/000", clk_o, busy_o);
    end
    checks++;
    if (cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_cfg_ready got=%b required 0", cfg_ready_o);
    end
`ifdef TB_CLK_GEN_MC_LOCK_EN
    checks++;
    if (lock_o !== '0) begin
      failures++;
      $display("FAIL reset_lock got=%b required 000", lock_o);
    end
`endif
    do_reset();
    en_i[1] = 1'b1;
    tick();
    checks++;
    if (clk_o !== 3'b010 || busy_o !== 3'b010) begin
      failures++;
      $display("FAIL first_rise clk_o=%b busy_o=%b required 010/010", clk_o, busy_o);
    end
    tick();
    checks++;
    if (clk_o !== 3'b000) begin
      failures++;
      $display("FAIL rst_div_low clk_o=%b required 000", clk_o);
    end
    en_i = '0;
    tick();
    checks++;
    if (busy_o !== 3'b000 || clk_o !== 3'b000) begin
      failures++;
      $display("FAIL rst_div_stop busy_o=%b clk_o=%b required 000/000", busy_o, clk_o);
    end
  endtask

  task automatic test_ch0_delay();
    bit pat [11] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd4; cfg_dly_i = 16'd3;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ch0_cfg_ready got=%b required 1", cfg_ready_o);
    end
    tick();
    cfg_valid_i = 1'b0;
    en_i[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (clk_o[0] !== pat[i] || busy_o[0] !== 1'b1) begin
        failures++;
        $display("FAIL ch0_delay_pattern cyc=%0d clk=%b busy=%b required %b/1", i, clk_o[0], busy_o[0], pat[i]);
      end
    end
  endtask

  task automatic test_ch1_dly0();
    bit pat [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [N_CH-1:0] e;
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 8'd5; cfg_dly_i = 16'd0;
    en_i[1] = 1'b1;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ch1_cfg_ready got=%b required 1", cfg_ready_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      cfg_valid_i = 1'b0;
      e = exp_clk();
      checks++;
      if (clk_o[1] !== pat[i] || clk_o[0] !== e[0]) begin
        failures++;
        $display("FAIL ch1_div5 cyc=%0d clk_o=%b required ch1=%b ch0=%b", i, clk_o, pat[i], e[0]);
      end
    end
  endtask

  task automatic test_stop();
    bit cpat [4] = '{1, 0, 0, 0};
    bit bpat [4] = '{1, 1, 1, 0};
    bit found;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (m_run[0] && m_phase[0] == 0) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stop_align timeout got=0 required 1");
    end
    en_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (clk_o[0] !== cpat[i] || busy_o[0] !== bpat[i]) begin
        failures++;
        $display("FAIL stop_finish cyc=%0d clk=%b busy=%b required %b/%b", i, clk_o[0], busy_o[0], cpat[i], bpat[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clk_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL stop_no_runt cyc=%0d clk=%b busy=%b required 0/0", i, clk_o[0], busy_o[0]);
      end
    end
  endtask

  task automatic test_cfg_busy();
    bit tpat [6] = '{1, 0, 1, 0, 1, 0};
    logic [N_CH-1:0] e;
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 8'd9; cfg_dly_i = 16'd7;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (cfg_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL busy_cfg_ready cyc=%0d got=%b required 0", i, cfg_ready_o);
      end
      tick();
      e = exp_clk();
      checks++;
      if (clk_o[1] !== e[1]) begin
        failures++;
        $display("FAIL busy_period cyc=%0d clk1=%b required %b", i, clk_o[1], e[1]);
      end
    end
    cfg_ch_i = 2'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (cfg_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL oor_cfg_ready cyc=%0d got=%b required 0", i, cfg_ready_o);
      end
      tick();
    end
    cfg_ch_i = 2'd0; cfg_div_i = 8'd1; cfg_dly_i = 16'd0;
    en_i[0] = 1'b1;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL div1_cfg_ready got=%b required 1", cfg_ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if (clk_o[0] !== tpat[i]) begin
        failures++;
        $display("FAIL div1_clamp cyc=%0d clk0=%b required %b", i, clk_o[0], tpat[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_div_i = 8'd6; cfg_dly_i = 16'd5;
    tick();
    cfg_valid_i = 1'b0;
    en_i[0] = 1'b1;
    tick();
    checks++;
    if (clk_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre clk0=%b required 1", clk_o[0]);
    end
    #3;
    rst_ni = 1'b0; cfg_valid_i = 1'b1; cfg_ch_i = 2'd0;
    model_reset();
    #1;
    checks++;
    if (clk_o !== '0 || busy_o !== '0 || cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL arst_async clk_o=%b busy_o=%b ready=%b required 000/000/0", clk_o, busy_o, cfg_ready_o);
    end
    @(posedge clk_i);
    #1;
    en_i = '0; cfg_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    en_i[2] = 1'b1;
    tick();
    checks++;
    if (clk_o !== 3'b100) begin
      failures++;
      $display("FAIL arst_cfg_dly clk_o=%b required 100", clk_o);
    end
    tick();
    checks++;
    if (clk_o !== 3'b000 || busy_o !== 3'b100) begin
      failures++;
      $display("FAIL arst_cfg_div clk_o=%b busy_o=%b required 000/100", clk_o, busy_o);
    end
  endtask

`ifdef TB_CLK_GEN_MC_LOCK_EN
  task automatic test_lock();
    do_reset();
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd4; cfg_dly_i = 16'd0;
    en_i[0] = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if (lock_o[0] !== (i >= 17)) begin
        failures++;
        $display("FAIL lock_rise edge=%0d got=%b required %b", i, lock_o[0], (i >= 17));
      end
    end
    en_i = '0;
    for (int i = 0; i < 8 && busy_o[0]; i++) tick();
    checks++;
    if (lock_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL lock_clear lock=%b busy=%b required 0/0", lock_o[0], busy_o[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [N_CH-1:0] e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(7) == 0) en_i[ch] = ~en_i[ch];
      end
      cfg_valid_i = ($urandom_range(3) == 0);
      cfg_ch_i    = 2'($urandom_range(3));
      cfg_div_i   = 8'($urandom_range(7));
      cfg_dly_i   = 16'($urandom_range(4));
      #1;
      checks++;
      if (cfg_ready_o !== model_ready()) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b required %b", c, cfg_ready_o, model_ready());
      end
      tick();
      e = exp_clk();
      checks++;
      if (clk_o !== e) begin
        failures++;
        $display("FAIL rand_clk cyc=%0d got=%b required %b", c, clk_o, e);
      end
      e = exp_busy();
      checks++;
      if (busy_o !== e) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d got=%b required %b", c, busy_o, e);
      end
`ifdef TB_CLK_GEN_MC_LOCK_EN
      e = exp_lock();
      checks++;
      if (lock_o !== e) begin
        failures++;
        $display("FAIL rand_lock cyc=%0d got=%b required %b", c, lock_o, e);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_ch0_delay();
    test_ch1_dly0();
    test_stop();
    test_cfg_busy();
    test_async_reset();
`ifdef TB_CLK_GEN_MC_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running required finished");
    $fatal(1, "watchdog");
  end

endmodule
